// File: rtl/ras_ctrl.sv
// Return-address-stack sequencing controller: forwards call/return as push/pop,
// tracks valid-entry occupancy, runs the flush-and-hold recovery sequence, keeps stats.

package config_pkg;
    typedef struct packed {
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd64};
endpackage

module ras_ctrl #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg     = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH       = 2,
    parameter int unsigned           HOLD_CYCLES = 2,
    parameter int unsigned           CNT_W       = 16,
    localparam int unsigned          OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      recover_i,
    input  logic                      call_valid_i,
    input  logic                      ret_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0]   call_ra_i,
    output logic                      req_ready_o,
    output logic                      ras_push_o,
    output logic                      ras_pop_o,
    output logic [CVA6Cfg.VLEN-1:0]   ras_data_o,
    output logic                      ras_flush_o,
    output logic [OCC_W-1:0]          occupancy_o,
    output logic                      ret_hit_o,
    input  logic                      stats_clear_i,
    output logic [CNT_W-1:0]          stat_push_o,
    output logic [CNT_W-1:0]          stat_pop_o,
    output logic [CNT_W-1:0]          stat_underflow_o
);

    localparam int unsigned HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [HC_W-1:0]   r_hold_cnt;
    logic [HC_W-1:0]   w_hold_cnt_nxt;
    logic [OCC_W-1:0]  r_occ;
    logic [OCC_W-1:0]  w_occ_nxt;
    logic [CNT_W-1:0]  r_stat [3];
    logic [2:0]        w_stat_inc;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_ret_hit;
    logic              w_underflow;

    // Recovery sequencer: RUN -> FLUSH (1 cycle) -> HOLD (HOLD_CYCLES) -> RUN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= RUN;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        unique case (r_state)
            RUN: begin
                if (recover_i) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (recover_i) begin
                    w_state_nxt = FLUSH;
                end else begin
                    w_state_nxt    = HOLD;
                    w_hold_cnt_nxt = HC_W'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (recover_i) begin
                    w_state_nxt = FLUSH;
                end else if (r_hold_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign w_ready = (r_state == RUN) && !recover_i;
    assign w_push  = call_valid_i && w_ready;
    assign w_pop   = ret_valid_i && w_ready;

    // Occupancy tracking; simultaneous push+pop replaces the top entry.
    always_comb begin
        w_occ_nxt   = r_occ;
        w_ret_hit   = 1'b0;
        w_underflow = 1'b0;
        if (r_state == FLUSH) begin
            w_occ_nxt = '0;
        end else if (w_push && w_pop) begin
            w_ret_hit   = (r_occ != '0);
            w_underflow = (r_occ == '0);
            if (r_occ == '0) begin
                w_occ_nxt = OCC_W'(1);
            end
        end else if (w_push) begin
            if (r_occ != OCC_W'(DEPTH)) begin
                w_occ_nxt = r_occ + 1'b1;
            end
        end else if (w_pop) begin
            if (r_occ != '0) begin
                w_occ_nxt = r_occ - 1'b1;
                w_ret_hit = 1'b1;
            end else begin
                w_underflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    assign w_stat_inc = {w_underflow, w_pop, w_push};

    // Saturating counters; clear wins over a same-cycle increment, flush leaves them alone.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 3; i++) begin
                r_stat[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (stats_clear_i) begin
                    r_stat[i] <= '0;
                end else if (w_stat_inc[i] && (r_stat[i] != '1)) begin
                    r_stat[i] <= r_stat[i] + 1'b1;
                end
            end
        end
    end

    assign req_ready_o      = w_ready;
    assign ras_push_o       = w_push;
    assign ras_pop_o        = w_pop;
    assign ras_data_o       = call_ra_i;
    assign ras_flush_o      = (r_state == FLUSH);
    assign occupancy_o      = r_occ;
    assign ret_hit_o        = w_ret_hit;
    assign stat_push_o      = r_stat[0];
    assign stat_pop_o       = r_stat[1];
    assign stat_underflow_o = r_stat[2];

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl (DEPTH=2, HOLD_CYCLES=2, CNT_W=4).

module tb_ras_ctrl;

    localparam int unsigned VLEN  = config_pkg::cva6_cfg_empty.VLEN;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned HOLD  = 2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              recover_i;
    logic              call_valid_i;
    logic              ret_valid_i;
    logic [VLEN-1:0]   call_ra_i;
    logic              req_ready_o;
    logic              ras_push_o;
    logic              ras_pop_o;
    logic [VLEN-1:0]   ras_data_o;
    logic              ras_flush_o;
    logic [OCC_W-1:0]  occupancy_o;
    logic              ret_hit_o;
    logic              stats_clear_i;
    logic [CNT_W-1:0]  stat_push_o;
    logic [CNT_W-1:0]  stat_pop_o;
    logic [CNT_W-1:0]  stat_underflow_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk_i = ~clk_i;

    ras_ctrl #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .recover_i        (recover_i),
        .call_valid_i     (call_valid_i),
        .ret_valid_i      (ret_valid_i),
        .call_ra_i        (call_ra_i),
        .req_ready_o      (req_ready_o),
        .ras_push_o       (ras_push_o),
        .ras_pop_o        (ras_pop_o),
        .ras_data_o       (ras_data_o),
        .ras_flush_o      (ras_flush_o),
        .occupancy_o      (occupancy_o),
        .ret_hit_o        (ret_hit_o),
        .stats_clear_i    (stats_clear_i),
        .stat_push_o      (stat_push_o),
        .stat_pop_o       (stat_pop_o),
        .stat_underflow_o (stat_underflow_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic call, input logic ret, input logic [63:0] ra,
                         input logic rec, input logic clr);
        call_valid_i  = call;
        ret_valid_i   = ret;
        call_ra_i     = VLEN'(ra);
        recover_i     = rec;
        stats_clear_i = clr;
        #2;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Recovery tables, index 0 is the recover cycle "10".
    logic       t4_rec   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       t4_rdy   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       t4_fl    [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] t4_occ   [5] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    logic       t5_rec   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       t5_rdy   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       t5_fl    [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    logic [63:0] ra_tab  [3] = '{64'h100, 64'h200, 64'h300};
    logic [1:0]  occ_c   [3] = '{2'd1, 2'd2, 2'd2};
    logic        hit_r   [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0]  occ_r   [3] = '{2'd1, 2'd0, 2'd0};

    initial begin
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_occ",   64'(occupancy_o), 64'd0);
        chk("rst_spush", 64'(stat_push_o), 64'd0);
        chk("rst_spop",  64'(stat_pop_o), 64'd0);
        chk("rst_sund",  64'(stat_underflow_o), 64'd0);
        chk("rst_flush", 64'(ras_flush_o), 64'd0);
        chk("rst_push",  64'(ras_push_o), 64'd0);
        chk("rst_pop",   64'(ras_pop_o), 64'd0);
        chk("rst_hit",   64'(ret_hit_o), 64'd0);
        rst_ni = 1'b1;
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'd1);

        // Three calls into a 2-deep RAS
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, ra_tab[i], 1'b0, 1'b0);
            chk("call_push", 64'(ras_push_o), 64'd1);
            chk("call_pop",  64'(ras_pop_o), 64'd0);
            chk("call_data", 64'(ras_data_o), ra_tab[i]);
            step();
            chk("call_occ",  64'(occupancy_o), 64'(occ_c[i]));
        end
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("call_spush", 64'(stat_push_o), 64'd3);

        // Three returns from occ=2, last one underflows
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 64'h0, 1'b0, 1'b0);
            chk("ret_pop", 64'(ras_pop_o), 64'd1);
            chk("ret_hit", 64'(ret_hit_o), 64'(hit_r[i]));
            step();
            chk("ret_occ", 64'(occupancy_o), 64'(occ_r[i]));
        end
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("ret_sund", 64'(stat_underflow_o), 64'd1);
        chk("ret_spop", 64'(stat_pop_o), 64'd3);

        // Clear stats, then call+ret together at occ=0
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        chk("clr_spush", 64'(stat_push_o), 64'd0);
        chk("clr_sund",  64'(stat_underflow_o), 64'd0);
        drive(1'b1, 1'b1, 64'h400, 1'b0, 1'b0);
        chk("cr_push", 64'(ras_push_o), 64'd1);
        chk("cr_pop",  64'(ras_pop_o), 64'd1);
        chk("cr_hit",  64'(ret_hit_o), 64'd0);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("cr_occ",   64'(occupancy_o), 64'd1);
        chk("cr_sund",  64'(stat_underflow_o), 64'd1);
        chk("cr_spush", 64'(stat_push_o), 64'd1);

        // Recovery pulse with a call held valid
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 64'h500, t4_rec[c], 1'b0);
            chk($sformatf("rec_ready_c%0d", 10 + c), 64'(req_ready_o), 64'(t4_rdy[c]));
            chk($sformatf("rec_flush_c%0d", 10 + c), 64'(ras_flush_o), 64'(t4_fl[c]));
            chk($sformatf("rec_push_c%0d", 10 + c),  64'(ras_push_o), 64'(t4_rdy[c]));
            chk($sformatf("rec_occ_c%0d", 10 + c),   64'(occupancy_o), 64'(t4_occ[c]));
            chk("rec_data", 64'(ras_data_o), 64'h500);
            step();
        end
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("rec_occ_after", 64'(occupancy_o), 64'd1);

        // Recovery re-triggered during HOLD
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, 1'b0, 64'h0, t5_rec[c], 1'b0);
            chk($sformatf("rer_ready_c%0d", 10 + c), 64'(req_ready_o), 64'(t5_rdy[c]));
            chk($sformatf("rer_flush_c%0d", 10 + c), 64'(ras_flush_o), 64'(t5_fl[c]));
            step();
        end

        // Saturation with CNT_W=4
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b0, 64'(i), 1'b0, 1'b0);
            step();
            if (i >= 15) begin
                chk($sformatf("sat_spush_%0d", i), 64'(stat_push_o), 64'd15);
            end
        end
        chk("sat_occ", 64'(occupancy_o), 64'd2);
        drive(1'b1, 1'b0, 64'h600, 1'b0, 1'b1);
        chk("satclr_push", 64'(ras_push_o), 64'd1);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("satclr_spush", 64'(stat_push_o), 64'd0);

        // Reset during FLUSH aborts without completing the sequence
        drive(1'b1, 1'b0, 64'h700, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("mid_flush", 64'(ras_flush_o), 64'd1);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        #1;
        chk("mid_flush_after", 64'(ras_flush_o), 64'd0);
        chk("mid_ready",       64'(req_ready_o), 64'd1);
        chk("mid_occ",         64'(occupancy_o), 64'd0);
        chk("mid_spush",       64'(stat_push_o), 64'd0);
        step();
        chk("mid_ready_next",  64'(req_ready_o), 64'd1);
        chk("mid_flush_next",  64'(ras_flush_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
